// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM for an iterative AES-128/192/256 datapath.
// It loads the text and key beats, then issues one step strobe at a time for each round. A watchdog aborts a step whose ack does not arrive.
module aes_round_sequencer #(
  parameter int KEY_BITS = 128,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [127:0]        data,
  input  logic                i_data_received_text,
  input  logic                i_data_received_key,
  input  logic                i_byte_subs,
  input  logic                i_shift_rows,
  input  logic                i_mix_columns,
  input  logic                i_key_addition,
  input  logic                i_round_key_get_ready,
  input  logic [127:0]        state_in,
  input  logic                i_done,
  output logic                o_load,
  output logic                o_process,
  output logic                o_send,
  output logic                o_substitute,
  output logic                o_shift_rows,
  output logic                o_mix_columns,
  output logic                o_add,
  output logic                o_calc_round_key,
  output logic                o_inverse,
  output logic [3:0]          round_cnt,
  output logic [127:0]        plain_text,
  output logic [KEY_BITS-1:0] prime_key,
  output logic [127:0]        cipher_text,
  output logic                o_error
);
  localparam logic [3:0] NR = KEY_BITS == 256 ? 4'd14 : KEY_BITS == 192 ? 4'd12 : 4'd10;
  localparam int KEY_BEATS = KEY_BITS == 128 ? 1 : 2;
  localparam int LB = KEY_BITS > 128 ? KEY_BITS - 128 : 1;
  localparam int WDW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, PROCESS, SEND} top_t;
  typedef enum logic [2:0] {ST_SUB, ST_SHIFT, ST_MIX, ST_ADD, ST_KEY, ST_DONE} step_t;
  top_t           r_state;
  step_t          r_step;
  step_t          w_next;
  logic           r_text_got;
  logic           r_kbeat;
  logic [WDW-1:0] r_wd;
  logic [127:0]   r_key_hi;
  logic           w_strobe, w_ack, w_last, w_timeout, w_kb0, w_kb1;
  assign o_load    = r_state == LOAD;
  assign o_process = r_state == PROCESS;
  assign o_send    = r_state == SEND;
  assign w_strobe  = o_substitute | o_shift_rows | o_mix_columns | o_add | o_calc_round_key;
  assign w_ack     = (o_substitute & i_byte_subs) | (o_shift_rows & i_shift_rows) |
                     (o_mix_columns & i_mix_columns) | (o_add & i_key_addition) |
                     (o_calc_round_key & i_round_key_get_ready);
  assign w_last    = o_inverse ? (round_cnt == 4'd0) : (round_cnt == NR);
  assign w_timeout = (TIMEOUT != 0) && w_strobe && (r_wd == WDW'(TIMEOUT - 1));
  assign w_kb0     = o_load && i_data_received_key && r_text_got && !r_kbeat;
  assign w_kb1     = o_load && i_data_received_key && r_text_got && r_kbeat && (KEY_BEATS == 2);
  // Decrypt runs InvShift/InvSub/Add/InvMix per round; the init ADD (round NR) goes straight to KEY.
  always_comb begin
    w_next = ST_DONE;
    if (!o_inverse)
      case (r_step)
        ST_SUB:   w_next = ST_SHIFT;
        ST_SHIFT: w_next = w_last ? ST_ADD : ST_MIX;
        ST_MIX:   w_next = ST_ADD;
        ST_ADD:   w_next = w_last ? ST_DONE : ST_KEY;
        ST_KEY:   w_next = ST_SUB;
        default:  w_next = ST_DONE;
      endcase
    else
      case (r_step)
        ST_SHIFT: w_next = ST_SUB;
        ST_SUB:   w_next = ST_ADD;
        ST_ADD:   w_next = w_last ? ST_DONE : (round_cnt == NR ? ST_KEY : ST_MIX);
        ST_MIX:   w_next = ST_KEY;
        ST_KEY:   w_next = ST_SHIFT;
        default:  w_next = ST_DONE;
      endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_step           <= ST_SUB;
      r_text_got       <= 1'b0;
      r_kbeat          <= 1'b0;
      r_wd             <= '0;
      r_key_hi         <= '0;
      o_substitute     <= 1'b0;
      o_shift_rows     <= 1'b0;
      o_mix_columns    <= 1'b0;
      o_add            <= 1'b0;
      o_calc_round_key <= 1'b0;
      o_inverse        <= 1'b0;
      round_cnt        <= '0;
      plain_text       <= '0;
      cipher_text      <= '0;
      o_error          <= 1'b0;
    end else begin
      o_error <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state    <= LOAD;
          o_inverse  <= mode;
          r_text_got <= 1'b0;
          r_kbeat    <= 1'b0;
        end
        LOAD: begin
          if (i_data_received_text && !r_text_got) begin
            plain_text <= data;
            r_text_got <= 1'b1;
          end
          if (w_kb0) begin
            r_key_hi <= data;
            r_kbeat  <= 1'b1;
          end
          if (KEY_BEATS == 1 ? w_kb0 : w_kb1) begin
            r_state   <= PROCESS;
            r_step    <= ST_ADD;
            o_add     <= 1'b1;
            r_wd      <= '0;
            round_cnt <= o_inverse ? NR : 4'd0;
          end
        end
        PROCESS: begin
          if (w_ack) begin
            {o_substitute, o_shift_rows, o_mix_columns, o_add, o_calc_round_key} <= '0;
            r_step <= w_next;
            if (o_calc_round_key) round_cnt <= o_inverse ? round_cnt - 4'd1 : round_cnt + 4'd1;
            if (o_add && w_next == ST_DONE) cipher_text <= state_in;
          end else if (w_timeout) begin
            {o_substitute, o_shift_rows, o_mix_columns, o_add, o_calc_round_key} <= '0;
            o_error   <= 1'b1;
            r_state   <= IDLE;
            round_cnt <= '0;
          end else if (w_strobe) begin
            r_wd <= r_wd + WDW'(1);
          end else if (r_step == ST_DONE) begin
            r_state <= SEND;
          end else begin
            o_substitute     <= r_step == ST_SUB;
            o_shift_rows     <= r_step == ST_SHIFT;
            o_mix_columns    <= r_step == ST_MIX;
            o_add            <= r_step == ST_ADD;
            o_calc_round_key <= r_step == ST_KEY;
            r_wd             <= '0;
          end
        end
        SEND: if (i_done) r_state <= IDLE;
      endcase
    end
  end
  if (KEY_BITS > 128) begin : g_lo
    logic [LB-1:0] r_key_lo;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_key_lo <= '0;
      else if (w_kb1) r_key_lo <= data[127 -: LB];
    end
    assign prime_key = {r_key_hi, r_key_lo};
  end else begin : g_nolo
    assign prime_key = r_key_hi;
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed bench over AES-128/192/256 instances sharing one stimulus bus.
// A small monitor counts strobe rises and records the expected cipher and timing for the selected instance.
module tb_aes_round_sequencer;
  logic clk = 0, reset = 0, start = 0, mode = 0, txt = 0, key = 0, i_done = 0;
  logic [127:0] data = '0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [127:0] state_in;
  assign state_in = {96'h29C3505F571420F6402299B3, cyc[31:0]};
  logic [1:0] sel = 0;
  logic auto = 0;
  logic [4:0] hold = 0, xack = 0;
  logic [3:0] hold_rc = 0;
  wire [4:0] a_stb, b_stb, c_stb, m_stb, ack;
  wire [2:0] a_fl, b_fl, c_fl, m_fl;
  wire a_inv, b_inv, c_inv, a_err, b_err, c_err, m_inv, m_err;
  wire [3:0] a_rc, b_rc, c_rc, m_rc;
  wire [127:0] a_pt, b_pt, c_pt, a_ct, b_ct, c_ct, m_pt, m_ct;
  wire [127:0] a_pk;
  wire [191:0] b_pk;
  wire [255:0] c_pk;
  assign m_stb = sel == 0 ? a_stb : sel == 1 ? b_stb : c_stb;
  assign m_fl  = sel == 0 ? a_fl  : sel == 1 ? b_fl  : c_fl;
  assign m_inv = sel == 0 ? a_inv : sel == 1 ? b_inv : c_inv;
  assign m_err = sel == 0 ? a_err : sel == 1 ? b_err : c_err;
  assign m_rc  = sel == 0 ? a_rc  : sel == 1 ? b_rc  : c_rc;
  assign m_pt  = sel == 0 ? a_pt  : sel == 1 ? b_pt  : c_pt;
  assign m_ct  = sel == 0 ? a_ct  : sel == 1 ? b_ct  : c_ct;
  assign ack = (auto ? (m_stb & ~(hold & {5{m_rc == hold_rc}})) : 5'b0) | xack;

  aes_round_sequencer #(.KEY_BITS(128)) u_a (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data(data),
    .i_data_received_text(txt), .i_data_received_key(key),
    .i_byte_subs(ack[0]), .i_shift_rows(ack[1]), .i_mix_columns(ack[2]),
    .i_key_addition(ack[3]), .i_round_key_get_ready(ack[4]),
    .state_in(state_in), .i_done(i_done),
    .o_load(a_fl[0]), .o_process(a_fl[1]), .o_send(a_fl[2]),
    .o_substitute(a_stb[0]), .o_shift_rows(a_stb[1]), .o_mix_columns(a_stb[2]),
    .o_add(a_stb[3]), .o_calc_round_key(a_stb[4]), .o_inverse(a_inv),
    .round_cnt(a_rc), .plain_text(a_pt), .prime_key(a_pk), .cipher_text(a_ct), .o_error(a_err));
  aes_round_sequencer #(.KEY_BITS(192)) u_b (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data(data),
    .i_data_received_text(txt), .i_data_received_key(key),
    .i_byte_subs(ack[0]), .i_shift_rows(ack[1]), .i_mix_columns(ack[2]),
    .i_key_addition(ack[3]), .i_round_key_get_ready(ack[4]),
    .state_in(state_in), .i_done(i_done),
    .o_load(b_fl[0]), .o_process(b_fl[1]), .o_send(b_fl[2]),
    .o_substitute(b_stb[0]), .o_shift_rows(b_stb[1]), .o_mix_columns(b_stb[2]),
    .o_add(b_stb[3]), .o_calc_round_key(b_stb[4]), .o_inverse(b_inv),
    .round_cnt(b_rc), .plain_text(b_pt), .prime_key(b_pk), .cipher_text(b_ct), .o_error(b_err));
  aes_round_sequencer #(.KEY_BITS(256)) u_c (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .data(data),
    .i_data_received_text(txt), .i_data_received_key(key),
    .i_byte_subs(ack[0]), .i_shift_rows(ack[1]), .i_mix_columns(ack[2]),
    .i_key_addition(ack[3]), .i_round_key_get_ready(ack[4]),
    .state_in(state_in), .i_done(i_done),
    .o_load(c_fl[0]), .o_process(c_fl[1]), .o_send(c_fl[2]),
    .o_substitute(c_stb[0]), .o_shift_rows(c_stb[1]), .o_mix_columns(c_stb[2]),
    .o_add(c_stb[3]), .o_calc_round_key(c_stb[4]), .o_inverse(c_inv),
    .round_cnt(c_rc), .plain_text(c_pt), .prime_key(c_pk), .cipher_text(c_ct), .o_error(c_err));

  logic [3:0] m_nr, fin_rc;
  assign m_nr   = sel == 0 ? 4'd10 : sel == 1 ? 4'd12 : 4'd14;
  assign fin_rc = mode ? 4'd0 : m_nr;
  logic [4:0] p_stb = 0;
  int n_tot, n_mix, n_key, n_fmix, n_oh, n_err, first_rc, t_ack, t_send, t_sh3, t_err;
  logic [127:0] exp_ct;
  always @(negedge clk) begin
    if (!$onehot0(m_stb)) n_oh++;
    for (int k = 0; k < 5; k++)
      if (m_stb[k] && !p_stb[k]) begin
        n_tot++;
        if (first_rc < 0) first_rc = int'(m_rc);
      end
    if (m_stb[2] && !p_stb[2]) n_mix++;
    if (m_stb[4] && !p_stb[4]) n_key++;
    if (m_stb[2] && !p_stb[2] && m_rc == fin_rc) n_fmix++;
    if (m_stb[1] && !p_stb[1] && m_rc == 4'd3 && t_sh3 < 0) t_sh3 = cyc;
    if (m_stb[3] && ack[3] && m_rc == fin_rc) begin
      exp_ct = state_in;
      t_ack = cyc;
    end
    if (m_fl[2] && t_send < 0) t_send = cyc;
    if (m_err) begin
      n_err++;
      if (t_err < 0) t_err = cyc;
    end
    p_stb = m_stb;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
    #1;
  endtask
  task automatic clr();
    n_tot = 0; n_mix = 0; n_key = 0; n_fmix = 0; n_oh = 0; n_err = 0;
    first_rc = -1; t_ack = -1; t_send = -1; t_sh3 = -1; t_err = -1; exp_ct = '0;
  endtask
  task automatic do_reset();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask
  task automatic go(input logic md, input logic [127:0] t, k0, k1, input int nb);
    mode = md;
    start = 1;
    tick();
    start = 0;
    data = t; txt = 1;
    tick();
    txt = 0; data = k0; key = 1;
    tick();
    if (nb == 2) begin
      data = k1;
      tick();
    end
    key = 0; data = '0;
  endtask
  task automatic wait_send(input int lim);
    int i = 0;
    while (!m_fl[2] && i < lim) begin
      smp();
      i++;
    end
    chk("send_reached", m_fl[2], 1);
  endtask
  task automatic chk_zero(input string p);
    chk({p, "_stb"}, a_stb, 0);
    chk({p, "_flags"}, a_fl, 0);
    chk({p, "_rc"}, a_rc, 0);
    chk({p, "_pt"}, a_pt, 0);
    chk({p, "_pk"}, a_pk, 0);
    chk({p, "_ct"}, a_ct, 0);
    chk({p, "_err_inv"}, {a_err, a_inv}, 0);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       md;
    int         nb;
    int         tot;
    int         mix;
    int         nkey;
    logic [3:0] rc0;
    logic [3:0] rcend;
  } rec_t;
  rec_t tab[4];
  logic [127:0] txt_v, k0_v, k1_v;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txt_v = 128'h54776F204F6E65204E696E652054776F;
    k0_v  = 128'h5468617473206D79204B756E67204675;
    k1_v  = 128'h000102030405060708090A0B0C0D0E0F;
    tab[0] = '{2'd0, 1'b0, 1, 50, 9, 10, 4'd0, 4'd10};
    tab[1] = '{2'd0, 1'b1, 1, 50, 9, 10, 4'd10, 4'd0};
    tab[2] = '{2'd2, 1'b0, 2, 70, 13, 14, 4'd0, 4'd14};
    tab[3] = '{2'd2, 1'b1, 2, 70, 13, 14, 4'd14, 4'd0};
    clr();
    smp();
    chk_zero("reset");
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      sel = tab[i].sel; auto = 1; hold = 0;
      clr();
      go(tab[i].md, txt_v, k0_v, k1_v, tab[i].nb);
      wait_send(400);
      chk($sformatf("v%0d_total", i), n_tot, tab[i].tot);
      chk($sformatf("v%0d_mix", i), n_mix, tab[i].mix);
      chk($sformatf("v%0d_key", i), n_key, tab[i].nkey);
      chk($sformatf("v%0d_final_mix", i), n_fmix, 0);
      chk($sformatf("v%0d_onehot", i), n_oh, 0);
      chk($sformatf("v%0d_first_rc", i), first_rc, tab[i].rc0);
      chk($sformatf("v%0d_end_rc", i), m_rc, tab[i].rcend);
      chk($sformatf("v%0d_send_lat", i), t_send - t_ack, 2);
      chk($sformatf("v%0d_ct", i), m_ct, exp_ct);
      chk($sformatf("v%0d_inv", i), m_inv, tab[i].md);
      chk($sformatf("v%0d_pt", i), m_pt, txt_v);
      if (tab[i].sel == 0) chk($sformatf("v%0d_pk", i), a_pk, k0_v);
      else chk($sformatf("v%0d_pk", i), c_pk, {k0_v, k1_v});
      repeat (3) smp();
      chk($sformatf("v%0d_ct_hold", i), m_ct, exp_ct);
      i_done = 1;
      tick();
      i_done = 0;
      smp();
      chk($sformatf("v%0d_idle", i), m_fl, 0);
    end
    // AES-192 load ordering: an early key beat is dropped, beat 1 fills the low 64 bits.
    do_reset();
    sel = 1; auto = 0;
    mode = 0; start = 1;
    tick();
    start = 0; data = k1_v; key = 1;
    tick();
    key = 0;
    smp();
    chk("k192_early_key", b_pk, 0);
    chk("k192_in_load", m_fl, 3'b001);
    data = txt_v; txt = 1;
    tick();
    txt = 0; data = k0_v; key = 1;
    tick();
    data = k1_v;
    tick();
    key = 0;
    smp();
    chk("k192_pk", b_pk, {k0_v, k1_v[127:64]});
    chk("k192_pk_lo", b_pk[63:0], k1_v[127:64]);
    chk("k192_pt", b_pt, txt_v);
    chk("k192_process", m_fl, 3'b010);
    // Watchdog: withhold the round-3 shift ack.
    do_reset();
    sel = 0; auto = 1; hold = 5'b00010; hold_rc = 3;
    clr();
    go(0, txt_v, k0_v, k1_v, 1);
    for (int i = 0; i < 300 && t_err < 0; i++) smp();
    chk("to_latency", t_err - t_sh3, 64);
    chk("to_strobes", m_stb, 0);
    chk("to_flags", m_fl, 0);
    chk("to_rc", m_rc, 0);
    chk("to_pt_kept", m_pt, txt_v);
    chk("to_pk_kept", a_pk, k0_v);
    smp();
    chk("to_pulse", {m_err, 4'(n_err)}, 5'd1);
    hold = 0;
    clr();
    go(0, txt_v, k0_v, k1_v, 1);
    wait_send(400);
    chk("to_restart_total", n_tot, 50);
    chk("to_restart_ct", m_ct, exp_ct);
    // Spurious mix ack and a start while SUB of round 2 is pending.
    do_reset();
    sel = 0; auto = 1; hold = 5'b00001; hold_rc = 2;
    clr();
    go(0, txt_v, k0_v, k1_v, 1);
    for (int i = 0; i < 200 && !(m_stb[0] && m_rc == 4'd2); i++) smp();
    xack = 5'b00100; start = 1;
    repeat (3) smp();
    chk("sp_stb", m_stb, 5'b00001);
    chk("sp_rc", m_rc, 2);
    chk("sp_flags", m_fl, 3'b010);
    xack = 0; start = 0; hold = 0;
    wait_send(400);
    chk("sp_total", n_tot, 50);
    chk("sp_mix", n_mix, 9);
    // Reset asserted during round 5.
    do_reset();
    sel = 0; auto = 1;
    clr();
    go(0, txt_v, k0_v, k1_v, 1);
    for (int i = 0; i < 200 && m_rc != 4'd5; i++) smp();
    chk("mr_reached_r5", m_rc, 5);
    reset = 0;
    #1;
    chk_zero("midrst");
    tick();
    reset = 1;
    clr();
    go(0, txt_v, k0_v, k1_v, 1);
    wait_send(400);
    chk("mr_total", n_tot, 50);
    chk("mr_first_rc", first_rc, 0);
    chk("mr_ct", m_ct, exp_ct);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
